// File: rtl/load_store_unit.sv
// Load/store unit: stalls the core, runs one word-aligned bus access, aligns/extends load data.
// Optional LSU_MISALIGN_TRAP_EN adds a misalign output and suppresses misaligned accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic        busErr
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] busyCnt;
  logic [2:0]    ldFunct3;
  logic [1:0]    ldOff;
  logic          req, isByte, isHalf, trap;
  logic [1:0]    off;
  logic [3:0]    stBe;
  logic [31:0]   stWdata, lane, ldVal;

  assign req    = memRead | memWrite;
  assign isByte = (funct3[1:0] == 2'b00);
  assign isHalf = (funct3[1:0] == 2'b01);
  // Low address bits that don't fit the access size are dropped, giving the aligned lane.
  assign off    = isByte ? aluResult[1:0] : isHalf ? {aluResult[1], 1'b0} : 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = (isHalf && aluResult[0]) || (!isByte && !isHalf && (aluResult[1:0] != 2'b00));
  assign misalign = !reset && (state == IDLE) && req && trap;
`else
  assign trap     = 1'b0;
`endif

  assign stall = !reset && (((state == IDLE) && req && !trap) || (state == BUSY));

  always_comb begin
    stBe    = 4'b1111;
    stWdata = writeData;
    if (isByte) begin
      stBe    = 4'b0001 << off;
      stWdata = {4{writeData[7:0]}};
    end else if (isHalf) begin
      stBe    = 4'b0011 << off;
      stWdata = {2{writeData[15:0]}};
    end
  end

  always_comb begin
    lane  = busRdata >> {ldOff, 3'b000};
    ldVal = lane;
    if (ldFunct3[1:0] == 2'b00)
      ldVal = {{24{~ldFunct3[2] & lane[7]}}, lane[7:0]};
    else if (ldFunct3[1:0] == 2'b01)
      ldVal = {{16{~ldFunct3[2] & lane[15]}}, lane[15:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busReq   <= 1'b0;
      busWe    <= 1'b0;
      busAddr  <= '0;
      busWdata <= '0;
      busBe    <= '0;
      readData <= '0;
      busErr   <= 1'b0;
      busyCnt  <= '0;
      ldFunct3 <= '0;
      ldOff    <= '0;
    end else begin
      busErr   <= 1'b0;
      readData <= '0;
      case (state)
        IDLE: if (req && !trap) begin
          state    <= BUSY;
          busReq   <= 1'b1;
          busWe    <= memWrite;
          busAddr  <= {aluResult[31:2], 2'b00};
          busWdata <= stWdata;
          busBe    <= memWrite ? stBe : 4'b1111;
          ldFunct3 <= funct3;
          ldOff    <= off;
          busyCnt  <= '0;
        end
        BUSY: begin
          if (busAck) begin
            state    <= DONE;
            busReq   <= 1'b0;
            readData <= busWe ? 32'd0 : ldVal;
          end else if (busyCnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state  <= DONE;
            busReq <= 1'b0;
            busErr <= 1'b1;
          end else begin
            busyCnt <= busyCnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: driver pushes expected bus/done records, monitor pops and compares.
module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk = 0, reset = 1, memRead = 0, memWrite = 0, busAck = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] aluResult = 0, writeData = 0, busRdata = 0;
  logic [31:0] readData, busAddr, busWdata;
  logic        stall, busReq, busWe, busErr;
  logic [3:0]  busBe;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we, err;
    logic [3:0]  be;
    int          stalls;
  } exp_t;
  exp_t busQ[$], doneQ[$];

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .aluResult(aluResult), .writeData(writeData), .readData(readData), .stall(stall),
    .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata), .busBe(busBe),
    .busAck(busAck), .busRdata(busRdata), .busErr(busErr)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: size from funct3, aligned lane offset, lane replication / extension by arithmetic.
  function automatic exp_t model(bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                 logic [31:0] rdat, int d);
    exp_t e;
    int size, off;
    logic [31:0] v, mask;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    off = off - (off % size);
    e.addr = a & 32'hFFFF_FFFC;
    e.we = wr; e.err = 0; e.rdata = 0; e.wdata = 0;
    if (wr) begin
      e.be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[i*8 +: 8] = wd[(i % size)*8 +: 8];
    end else begin
      e.be = 4'hF;
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*size)) - 32'h1;
      v = (rdat >> (8*off)) & mask;
      if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~mask;
      e.rdata = v;
    end
    if (d >= TO) begin e.err = 1; e.rdata = 0; e.stalls = TO + 1; end
    else e.stalls = d + 2;
    return e;
  endfunction

  // d = BUSY cycles before ack (>= TO: never acked); rst3 = assert reset in the 3rd BUSY cycle.
  task automatic runTxn(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                        logic [31:0] rdat, int d, bit rst3);
    exp_t e;
    int busyCnt;
    e = model(wr, f3, a, wd, rdat, d);
    memRead = rd; memWrite = wr; funct3 = f3; aluResult = a; writeData = wd;
    busRdata = rdat; busAck = 0;
    busQ.push_back(e);
    if (!rst3) doneQ.push_back(e);
    busyCnt = 0;
    for (int g = 0; g < 100; g++) begin
      @(posedge clk); #1;
      if (busReq) begin
        if (rst3 && busyCnt == 2) begin
          reset = 1;
          @(posedge clk); #1;
          reset = 0; memRead = 0; memWrite = 0; busAck = 0;
          chk("rst_mid_busReq", 32'(busReq), 0);
          chk("rst_mid_stall", 32'(stall), 0);
          chk("rst_mid_busAddr", busAddr, 0);
          chk("rst_mid_busBe", 32'(busBe), 0);
          return;
        end
        busAck = (busyCnt == d);
        busyCnt++;
      end else if (g > 0) begin
        memRead = 0; memWrite = 0; busAck = 0;
        return;
      end
    end
    errors++;
    $display("FAIL txn_timeout actual=no_done required=done");
  endtask

  initial begin : monitor
    exp_t e, cur;
    logic prevReq;
    int   stallCnt;
    prevReq = 0; stallCnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevReq = 0; stallCnt = 0;
        continue;
      end
      if (busReq && !prevReq) begin
        if (busQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bus actual=busReq required=idle");
        end else begin
          cur = busQ.pop_front();
          chk("busAddr", busAddr, cur.addr);
          chk("busWe", 32'(busWe), 32'(cur.we));
          chk("busBe", 32'(busBe), 32'(cur.be));
          if (cur.we) chk("busWdata", busWdata, cur.wdata);
        end
      end else if (busReq) begin
        chk("hold_busAddr", busAddr, cur.addr);
        chk("hold_busBe", 32'(busBe), 32'(cur.be));
        chk("hold_busWe", 32'(busWe), 32'(cur.we));
      end
      if (prevReq && !busReq) begin
        if (doneQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=done required=none");
        end else begin
          e = doneQ.pop_front();
          chk("readData", readData, e.rdata);
          chk("busErr", 32'(busErr), 32'(e.err));
          chk("stall_cycles", 32'(stallCnt), 32'(e.stalls));
          chk("done_stall", 32'(stall), 0);
        end
        stallCnt = 0;
      end else begin
        if (stall) stallCnt++;
        chk("idle_readData", readData, 0);
        chk("idle_busErr", 32'(busErr), 0);
      end
      prevReq = busReq;
    end
  end

  initial begin : driver
    int op, d;
    logic [31:0] a;
    logic [2:0]  f3;
    @(posedge clk); #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busReq", 32'(busReq), 0);
    chk("rst_busWe", 32'(busWe), 0);
    chk("rst_busBe", 32'(busBe), 0);
    chk("rst_busAddr", busAddr, 0);
    chk("rst_busWdata", busWdata, 0);
    chk("rst_readData", readData, 0);
    chk("rst_busErr", 32'(busErr), 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(misalign), 0);
`endif
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    runTxn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);         // sw
    runTxn(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 0);         // lb
    runTxn(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 1, 0);         // lbu
    runTxn(0, 1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 2, 0);          // sh
    runTxn(1, 0, 3'b010, 32'h40, 32'h0, 32'h12345678, TO + 4, 0);     // lw timeout
    runTxn(1, 1, 3'b000, 32'h7, 32'h000000A5, 32'h0, 0, 0);           // write wins
    runTxn(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, TO + 4, 1);           // reset mid-access
`ifdef LSU_MISALIGN_TRAP_EN
    memRead = 1; funct3 = 3'b010; aluResult = 32'h102; #1;
    chk("misalign_pulse", 32'(misalign), 1);
    chk("misalign_stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("misalign_noReq", 32'(busReq), 0);
    memRead = 0;
    @(posedge clk); #1;
`else
    runTxn(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0);         // forced-aligned lw
`endif

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) a[0] = 0;
      else if (f3[1:0] != 2'b00) a[1:0] = 0;
`endif
      d = ($urandom_range(0, 14) == 0) ? TO + 2 : $urandom_range(0, 5);
      runTxn(op != 1, op != 0, f3, a, $urandom, $urandom, d, 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("busQ_drained", 32'(busQ.size()), 0);
    chk("doneQ_drained", 32'(doneQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
